cflog_tx_stream: RTL

Parametrised control-flow-log streamer for the attestation hardware. It captures the CF-Log pointer on boot, flush or ER completion, and on flush or ER completion walks entries 0..captured pointer inclusive. Each entry of ENTRY_W bits is serialised LSB-byte-first to a byte-wide transmitter through a valid/ready handshake, with a programmable idle gap between bytes. Compared with the previous controller, it adds:
- generic entry and pointer widths;
- back-pressure from the transmitter;
- repeatable sessions with a completion pulse.

---
 rtl/cflog_tx_stream.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cflog_tx_stream.sv
// Control-flow-log streamer: captures the log pointer and serialises entries LSB-byte-first.
// Define CFLOG_TX_HEADER_EN to prefix each session with the captured pointer bytes.
module cflog_tx_stream #(
  parameter int          ENTRY_W = 16,
  parameter int          PTR_W   = 16,
  parameter logic [15:0] GAP     = 16'hFFFF
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic [PTR_W-1:0]   cflow_log_ptr,
  input  logic               boot,
  input  logic               flush,
  input  logic               ER_done,
  input  logic [ENTRY_W-1:0] read_val,
  output logic [PTR_W-1:0]   read_idx,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done
);

  localparam int NBYTES = ENTRY_W / 8;
  localparam int CW     = 8;
`ifdef CFLOG_TX_HEADER_EN
  localparam int HBYTES = (PTR_W + 7) / 8;
  localparam int SW     = (HBYTES * 8 > ENTRY_W) ? HBYTES * 8 : ENTRY_W;
`else
  localparam int SW     = ENTRY_W;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef CFLOG_TX_HEADER_EN
    S_HDR,
`endif
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  state_t            acc_tgt;
  logic              acc;
  logic [PTR_W-1:0]  last_q, last_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [15:0]       gcnt_q, gcnt_d;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      last_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    last_d  = last_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    acc     = 1'b0;
    acc_tgt = S_SEND;
    unique case (state_q)
      S_IDLE: begin
        if (boot | flush | ER_done) last_d = cflow_log_ptr;
        if (flush | ER_done) begin
          idx_d = '0;
`ifdef CFLOG_TX_HEADER_EN
          shreg_d = SW'(cflow_log_ptr);
          bcnt_d  = '0;
          state_d = S_HDR;
`else
          state_d = S_LOAD;
`endif
        end
      end
`ifdef CFLOG_TX_HEADER_EN
      S_HDR: begin
        if (tx_ready) begin
          shreg_d = shreg_q >> 8;
          acc     = 1'b1;
          if (bcnt_q == CW'(HBYTES - 1)) begin
            acc_tgt = S_LOAD;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            acc_tgt = S_HDR;
          end
        end
      end
`endif
      S_LOAD: begin
        shreg_d = SW'(read_val);
        bcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (bcnt_q != CW'(NBYTES - 1)) begin
            shreg_d = shreg_q >> 8;
            bcnt_d  = bcnt_q + 1'b1;
            acc     = 1'b1;
            acc_tgt = S_SEND;
          end else if (idx_q == last_q) begin
            // equality, not magnitude: an all-ones pointer must not wrap
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            acc     = 1'b1;
            acc_tgt = S_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP - 16'd1) begin
          gcnt_d  = '0;
          state_d = ret_q;
        end else begin
          gcnt_d = gcnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (acc) begin
      if (GAP == 16'd0) begin
        state_d = acc_tgt;
      end else begin
        state_d = S_GAP;
        ret_d   = acc_tgt;
        gcnt_d  = '0;
      end
    end
  end

`ifdef CFLOG_TX_HEADER_EN
  assign tx_valid = (state_q == S_SEND) || (state_q == S_HDR);
`else
  assign tx_valid = (state_q == S_SEND);
`endif
  assign tx_data  = tx_valid ? shreg_q[7:0] : 8'h00;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign read_idx = idx_q;

endmodule
